// File: rtl/fifo_uart_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
package fifo_uart_pkg;

  localparam int unsigned DATA_W           = 8;
  localparam int unsigned CLKS_PER_BIT_DEF = 868;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // Even parity: the extra bit makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/fifo_uart_tx_if.sv
// Read-side handshake between the transmitter and its upstream byte FIFO.
interface fifo_uart_tx_if;
  import fifo_uart_pkg::*;

  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_data;
  logic              fifo_rd;

  modport master (input fifo_empty, input fifo_data, output fifo_rd);
  modport slave  (output fifo_empty, output fifo_data, input fifo_rd);

endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period counter: bit_tick marks the last clock of each UART bit.
module uart_baud_gen
  import fifo_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_tick
);

  localparam int unsigned    CNT_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  // Reload on every bit boundary so no phase error carries into the next bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear || bit_tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign bit_tick = (cnt == CNT_MAX);

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pulls one byte per frame from an upstream FIFO
// and serialises it as start / 8 data LSB-first / optional even parity / stop.
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int unsigned PARITY_EN    = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           enable,
  fifo_uart_tx_if.master fifo,
  output logic           tx,
  output logic           busy,
  output logic           tx_done
);

  state_t            state;
  logic [DATA_W-1:0] shreg;
  logic [2:0]        bit_idx;
  logic              par_bit;
  logic              rd_armed;
  logic              bit_tick;
  logic              baud_clear;

  // Counter is held at zero until the start bit so every frame starts in phase.
  assign baud_clear = (state == S_IDLE) || (state == S_FETCH);

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk      (clk),
    .rst      (rst),
    .clear    (baud_clear),
    .bit_tick (bit_tick)
  );

  // rd_armed blocks a read in the first cycle after reset release.
  assign fifo.fifo_rd = (state == S_IDLE) && rd_armed && enable && !fifo.fifo_empty;
  assign busy         = (state != S_IDLE) || fifo.fifo_rd;
  assign tx_done      = (state == S_STOP) && bit_tick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      tx       <= 1'b1;
      shreg    <= '0;
      bit_idx  <= '0;
      par_bit  <= 1'b0;
      rd_armed <= 1'b0;
    end else begin
      rd_armed <= 1'b1;
      unique case (state)
        S_IDLE: begin
          tx <= 1'b1;
          if (fifo.fifo_rd) begin
            state <= S_FETCH;
          end
        end
        S_FETCH: begin
          shreg   <= fifo.fifo_data;
          par_bit <= even_parity(fifo.fifo_data);
          bit_idx <= '0;
          tx      <= 1'b0;
          state   <= S_START;
        end
        S_START: begin
          if (bit_tick) begin
            tx    <= shreg[0];
            shreg <= {1'b0, shreg[DATA_W-1:1]};
            state <= S_DATA;
          end
        end
        S_DATA: begin
          // tx is loaded one bit ahead from the shift register's LSB.
          if (bit_tick) begin
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              if (PARITY_EN != 0) begin
                tx    <= par_bit;
                state <= S_PARITY;
              end else begin
                tx    <= 1'b1;
                state <= S_STOP;
              end
            end else begin
              tx    <= shreg[0];
              shreg <= {1'b0, shreg[DATA_W-1:1]};
            end
          end
        end
        S_PARITY: begin
          if (bit_tick) begin
            tx    <= 1'b1;
            state <= S_STOP;
          end
        end
        S_STOP: begin
          if (bit_tick) begin
            state <= S_IDLE;
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, clk cycles per UART bit (100 MHz / 115200); legal range >= 2.
REQ-002 SHALL have parameter PARITY_EN, default 0, 1 = append even-parity bit after data bits.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port enable  input  1  permits starting new frames.
REQ-006 SHALL have port fifo_empty  input  1  empty flag of upstream 8-bit FIFO.
REQ-007 SHALL have port fifo_data  input  8  FIFO read data, valid the cycle after fifo_rd.
REQ-008 SHALL have port fifo_rd  output  1  single-cycle FIFO read strobe.
REQ-009 SHALL have port tx  output  1  UART serial line, idle high.
REQ-010 SHALL have port busy  output  1  high from fifo_rd cycle through last stop-bit cycle.
REQ-011 SHALL have port tx_done  output  1  one-cycle pulse at end of stop bit.

Function
REQ-012 SHALL implement states IDLE, FETCH, START, DATA, PARITY, STOP.
REQ-013 IDLE: when enable=1 and fifo_empty=0, SHALL assert fifo_rd for exactly that cycle and go to FETCH; otherwise tx=1, fifo_rd=0.
REQ-014 fifo_rd SHALL never be asserted while fifo_empty=1 or outside IDLE (no underflow, max one read per frame).
REQ-015 FETCH: SHALL capture fifo_data into an 8-bit shift register, clear baud counter, go to START; fifo_empty changes during FETCH ignored.
REQ-016 START: tx=0 for exactly CLKS_PER_BIT cycles.
REQ-017 DATA: 8 bits LSB-first, each held exactly CLKS_PER_BIT cycles; 3-bit bit index, wraps 7->0 on exit.
REQ-018 PARITY (only if PARITY_EN=1): tx = XOR of the 8 captured bits, CLKS_PER_BIT cycles; skipped otherwise.
REQ-019 STOP: tx=1 for CLKS_PER_BIT cycles; tx_done=1 in last STOP cycle; then IDLE.
REQ-020 Baud counter SHALL be $clog2(CLKS_PER_BIT) bits, count 0..CLKS_PER_BIT-1, reload 0 on each bit boundary; no drift across frames.
REQ-021 Back-to-back: with FIFO non-empty, next start bit SHALL begin exactly 2 clk cycles (IDLE + FETCH) after previous stop bit ends.
REQ-022 enable deasserted mid-frame: current frame SHALL complete; no new fifo_rd until enable=1.
REQ-023 tx SHALL be driven from a register (glitch-free).

Reset
REQ-024 On rst=1, immediately: state=IDLE, tx=1, fifo_rd=0, busy=0, tx_done=0, counters and shift register 0.
REQ-025 Reset mid-frame SHALL abort the frame; in-flight byte discarded; no fifo_rd in the first cycle after release.

Structure
REQ-026 Package fifo_uart_pkg SHALL hold state enum, DATA_W=8, default CLKS_PER_BIT.
REQ-027 Baud counter SHALL be sub-module uart_baud_gen (clk, rst, clear, bit_tick).
REQ-028 Implementation SHALL be 120-400 lines RTL, no latches, no combinational loops.

Verification (CLKS_PER_BIT=4)
REQ-029 Reset with FIFO empty, enable=1 -> tx=1, fifo_rd never asserted for 100 cycles.
REQ-030 Write 0xA5 to FIFO, enable=1 -> one fifo_rd pulse; tx = 0,1,0,1,0,0,1,0,1,1 per 4-cycle bit; tx_done after 40 cycles of frame.
REQ-031 Fill 16 bytes 0x01..0x10 -> 16 frames in order, start-to-start period 42 cycles, fifo_rd count 16, no underflow flag.
REQ-032 PARITY_EN=1, byte 0x07 -> parity bit 1, frame 44 cycles; byte 0x03 -> parity bit 0.
REQ-033 rst=1 at bit 4 of 0x55 -> tx=1 same cycle; after release with FIFO empty, no frame and busy=0.
REQ-034 enable dropped during DATA of byte 0x3C with 2 bytes queued -> 0x3C completes, no further fifo_rd until enable=1.
